// File: rtl/q_edge_monitor_pkg.sv
// Shared definitions for the q_edge_monitor block: default widths and the
// two-value FSM state type used by the top and its interface.
package q_edge_monitor_pkg;

  // Default event counter width.
  localparam int COUNT_W_DEF = 8;

  // Default high-run length width.
  localparam int LEN_W_DEF = 8;

  // FSM state: tracks whether the monitored level is currently low or high.
  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_e;

endpackage : q_edge_monitor_pkg

// File: rtl/q_edge_monitor_if.sv
// Signal bundle for q_edge_monitor.
//
// Stream semantics: q_in is a level sampled on every rising clk edge. There
// is no valid/ready pair and no backpressure; every cycle is a sample and
// every output is a registered value that is valid each cycle after reset.
// clear is a one-cycle synchronous request, acted on at the next edge.
interface q_edge_monitor_if
  import q_edge_monitor_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int LEN_W   = LEN_W_DEF
) ();

  logic               q_in;
  logic               clear;
  logic               rise_pulse;
  logic               fall_pulse;
  logic [COUNT_W-1:0] event_count;
  logic [LEN_W-1:0]   high_len;
  logic               overflow;
  state_e             state_dbg;

  // Driver side: supplies the level and clear, observes statistics.
  modport master (
    output q_in,
    output clear,
    input  rise_pulse,
    input  fall_pulse,
    input  event_count,
    input  high_len,
    input  overflow,
    input  state_dbg
  );

  // Monitor side: consumes the level and clear, produces statistics.
  modport slave (
    input  q_in,
    input  clear,
    output rise_pulse,
    output fall_pulse,
    output event_count,
    output high_len,
    output overflow,
    output state_dbg
  );

endinterface : q_edge_monitor_if

// File: rtl/q_edge_monitor_edge_detect.sv
// Edge detector: keeps the previous sampled level and compares it with the
// current one. rise_det/fall_det are combinational and valid in the cycle
// the edge is sampled; rise_pulse/fall_pulse are the same events registered,
// so they appear for exactly one cycle after that edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise_det,
  output logic fall_det,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic prev_q;

  // Compare the current level against the previous one.
  always_comb begin
    rise_det = level & ~prev_q;
    fall_det = ~level & prev_q;
  end

  // Register the previous level and the one-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      prev_q     <= level;
      rise_pulse <= rise_det;
      fall_pulse <= fall_det;
    end
  end

endmodule : edge_detect

// File: rtl/q_edge_monitor.sv
// q_edge_monitor: watches a registered level, strobes on each rising and
// falling edge, counts rises (saturating, with a sticky overflow flag) and
// records the length of the most recent completed high run (saturating).
//
// Optional feature macro: Q_EDGE_MONITOR_FILTER_EN
//   When defined, the level passes through a two-sample glitch filter
//   before edge detection, adding one cycle of latency to the pulses and
//   suppressing single-cycle glitches. When undefined, q_in feeds edge
//   detection directly.
module q_edge_monitor
  import q_edge_monitor_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  q_edge_monitor_if.slave   bus
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [LEN_W-1:0]   RUN_MAX   = '1;

  // Level presented to edge detection and the FSM.
  logic level;

`ifdef Q_EDGE_MONITOR_FILTER_EN
  // Last raw sample and the current filtered level.
  logic q_d;
  logic filt_q;

  // The filtered level follows q_in only once two consecutive samples agree;
  // a disagreeing pair holds the previous filtered value.
  always_comb begin
    level = (bus.q_in == q_d) ? bus.q_in : filt_q;
  end

  // Hold the raw sample history and the filtered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_d    <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      q_d    <= bus.q_in;
      filt_q <= level;
    end
  end
`else
  // No filter: the sampled level goes straight to edge detection.
  always_comb begin
    level = bus.q_in;
  end
`endif

  // Edge detection and strobes.
  logic rise_det;
  logic fall_det;
  logic rise_pulse;
  logic fall_pulse;

  edge_detect u_edge_detect (
    .clk        (clk),
    .rst        (rst),
    .level      (level),
    .rise_det   (rise_det),
    .fall_det   (fall_det),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  // FSM state and statistics registers.
  state_e             state_q;
  state_e             state_d;
  logic [LEN_W-1:0]   run_q;
  logic [LEN_W-1:0]   run_d;
  logic [LEN_W-1:0]   high_len_q;
  logic [LEN_W-1:0]   high_len_d;
  logic [COUNT_W-1:0] event_count_q;
  logic [COUNT_W-1:0] event_count_d;
  logic               overflow_q;
  logic               overflow_d;

  // Next-state, run counter and statistics logic. clear is applied last so
  // it wins over a coincident rise or fall; it never touches the FSM or the
  // run counter.
  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    high_len_d    = high_len_q;
    event_count_d = event_count_q;
    overflow_d    = overflow_q;

    case (state_q)
      ST_LOW: begin
        if (level) begin
          state_d = ST_HIGH;
          run_d   = LEN_W'(1);
        end
      end
      ST_HIGH: begin
        if (level) begin
          if (run_q != RUN_MAX) begin
            run_d = run_q + LEN_W'(1);
          end
        end else begin
          state_d = ST_LOW;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ST_LOW;
        run_d   = '0;
      end
    endcase

    // A completed high run is published together with fall_pulse.
    if (fall_det) begin
      high_len_d = run_q;
    end

    // Count rises; a rise that cannot be counted raises the sticky flag.
    if (rise_det) begin
      if (event_count_q == COUNT_MAX) begin
        overflow_d = 1'b1;
      end else begin
        event_count_d = event_count_q + COUNT_W'(1);
      end
    end

    if (bus.clear) begin
      event_count_d = '0;
      high_len_d    = '0;
      overflow_d    = 1'b0;
    end
  end

  // State and statistics registers; reset discards any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_LOW;
      run_q         <= '0;
      high_len_q    <= '0;
      event_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      high_len_q    <= high_len_d;
      event_count_q <= event_count_d;
      overflow_q    <= overflow_d;
    end
  end

  // Drive the bundle outputs.
  always_comb begin
    bus.rise_pulse  = rise_pulse;
    bus.fall_pulse  = fall_pulse;
    bus.event_count = event_count_q;
    bus.high_len    = high_len_q;
    bus.overflow    = overflow_q;
    bus.state_dbg   = state_q;
  end

endmodule : q_edge_monitor
